// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480 scan-out of the 320x240x24 frame buffer.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_SRC_WIDTH = 320;

  localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int FB_DEPTH = 76800;
  localparam int ADDR_W   = 17;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Timing flags, all asserted-high; polarity is applied at the output register.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic frame_start;
  } ctrl_t;

  // y*320 + x as two shifted copies of y, avoiding a multiplier.
  function automatic logic [ADDR_W-1:0] fb_addr_320(input logic [8:0] x, input logic [7:0] y);
    return {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters and stage-0 timing flags; enable low parks the raster at the origin.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output ctrl_t      ctrl
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (!enable) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
    end else begin
      h_count <= h_count + 10'd1;
    end
  end

  // Flags are gated by enable so a disabled raster reads as blank with syncs idle.
  always_comb begin
    ctrl.active      = enable && (h_count < H_ACT) && (v_count < V_ACT);
    ctrl.hsync       = enable && (h_count >= HS_START) && (h_count < HS_END);
    ctrl.vsync       = enable && (v_count >= VS_START) && (v_count < VS_END);
    ctrl.frame_start = enable && (h_count == '0) && (v_count == '0);
  end

endmodule

// File: rtl/vga_framebuffer_scanout.sv
// VGA scan-out: 2x2-replicated frame-buffer reads, 3-clock aligned pipeline, registered DAC outputs.
module vga_framebuffer_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter int SRC_WIDTH       = DEF_SRC_WIDTH,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic              ul1Clock,
  input  logic              ul1Reset_n,
  input  logic              ul1Enable,
  output logic [ADDR_W-1:0] poul17ReadAddress,
  input  logic [23:0]       piul24ReadData,
  output logic [7:0]        poul8Red,
  output logic [7:0]        poul8Green,
  output logic [7:0]        poul8Blue,
  output logic              poul1HSync,
  output logic              poul1VSync,
  output logic              poul1Blank_n,
  output logic              poul1Sync_n,
  output logic              poul1FrameStart
);

  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  logic [9:0]        h_p0;
  logic [9:0]        v_p0;
  ctrl_t             ctrl_p0;
  ctrl_t             ctrl_p1;
  ctrl_t             ctrl_p2;
  logic [ADDR_W-1:0] addr_p1;
  rgb_t              rgb_p3;
  logic              vld_p3;
  logic              hsync_p3;
  logic              vsync_p3;
  logic              frame_start_p3;

  function automatic logic sync_level(input logic asserted);
    return (SYNC_ACTIVE_LOW != 0) ? ~asserted : asserted;
  endfunction

  // Source pixel address for a display coordinate; each source pixel covers a 2x2 block.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [9:0] h, input logic [9:0] v);
    logic [8:0] x;
    logic [8:0] y;
    x = 9'(h >> 1);
    y = 9'(v >> 1);
    if (SRC_WIDTH == 320) return fb_addr_320(x, y[7:0]);
    else return ADDR_W'(int'(y) * SRC_WIDTH + int'(x));
  endfunction

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clk     (ul1Clock),
    .rst_n   (ul1Reset_n),
    .enable  (ul1Enable),
    .h_count (h_p0),
    .v_count (v_p0),
    .ctrl    (ctrl_p0)
  );

  // Stage 1: read address issue; stage 2: buffer data returns alongside ctrl_p2.
  always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
    if (!ul1Reset_n) begin
      addr_p1 <= '0;
      ctrl_p1 <= '0;
      ctrl_p2 <= '0;
    end else begin
      addr_p1 <= ctrl_p0.active ? pixel_addr(h_p0, v_p0) : '0;
      ctrl_p1 <= ctrl_p0;
      ctrl_p2 <= ctrl_p1;
    end
  end

  // Stage 3: DAC output registers.
  always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
    if (!ul1Reset_n) begin
      rgb_p3         <= '0;
      vld_p3         <= 1'b0;
      hsync_p3       <= SYNC_IDLE;
      vsync_p3       <= SYNC_IDLE;
      frame_start_p3 <= 1'b0;
    end else begin
      rgb_p3         <= ctrl_p2.active ? rgb_t'(piul24ReadData) : '0;
      vld_p3         <= ctrl_p2.active;
      hsync_p3       <= sync_level(ctrl_p2.hsync);
      vsync_p3       <= sync_level(ctrl_p2.vsync);
      frame_start_p3 <= ctrl_p2.frame_start;
    end
  end

  assign poul17ReadAddress = addr_p1;
  assign poul8Red          = rgb_p3.r;
  assign poul8Green        = rgb_p3.g;
  assign poul8Blue         = rgb_p3.b;
  assign poul1HSync        = hsync_p3;
  assign poul1VSync        = vsync_p3;
  assign poul1Blank_n      = vld_p3;
  assign poul1Sync_n       = 1'b1;
  assign poul1FrameStart   = frame_start_p3;

endmodule
